// File: rtl/reflect_ray_gen_if.sv
// reflect_ray_gen_if: Q16.16 vector types, shared multiply and hit-in/ray-out handshake bundle
//   light_pack: fixed (signed Q16.16), vector/point (x,y,z), ray (start,dir), fMul (truncating product)
//   reflect_ray_gen_if: in_valid/in_ready + hit payload, out_valid/out_ready + ray payload, term_pulse
//   master drives hits and out_ready, slave is the generator
package light_pack;
  typedef logic signed [31:0] fixed;
  typedef struct packed {
    fixed x;
    fixed y;
    fixed z;
  } vector;
  typedef vector point;
  typedef struct packed {
    point  start;
    vector dir;
  } ray;
  function automatic fixed fMul(input fixed a, input fixed b);
    return fixed'((64'(a) * 64'(b)) >>> 16);
  endfunction
endpackage

interface reflect_ray_gen_if #(parameter int DEPTH_W = 4);
  import light_pack::*;
  logic               in_valid;
  logic               in_ready;
  point               in_point;
  vector              in_normal;
  vector              in_dir;
  logic [DEPTH_W-1:0] in_depth;
  logic               out_valid;
  logic               out_ready;
  ray                 out_ray;
  logic [DEPTH_W-1:0] out_depth;
  logic               term_pulse;
  modport master (
    output in_valid, in_point, in_normal, in_dir, in_depth, out_ready,
    input  in_ready, out_valid, out_ray, out_depth, term_pulse
  );
  modport slave (
    input  in_valid, in_point, in_normal, in_dir, in_depth, out_ready,
    output in_ready, out_valid, out_ray, out_depth, term_pulse
  );
endinterface

// File: rtl/reflect_ray_gen.sv
// reflect_ray_gen: mirror-reflected secondary ray from hit point/normal/dir using one shared multiplier
//   clk, rst_n (async active-low), bus (slave): hit in, reflected ray + depth out, term_pulse on depth drop
module reflect_ray_gen
  import light_pack::*;
#(
  parameter int EPS_SHIFT = 8,
  parameter int DEPTH_W   = 4,
  parameter int MAX_DEPTH = 3
) (
  input logic             clk,
  input logic             rst_n,
  reflect_ray_gen_if.slave bus
);
  if (MAX_DEPTH >= (1 << DEPTH_W)) begin : g_depth_check
    $error("MAX_DEPTH must be below 2**DEPTH_W so depth+1 cannot overflow");
  end
  typedef enum logic [3:0] {IDLE, DX, DY, DZ, SC, MX, MY, MZ, OUT} state_t;
  state_t             state, state_nx;
  point               p, start_r;
  vector              n, d;
  logic [DEPTH_W-1:0] depth, out_depth;
  fixed               acc, k, dir_x, dir_y, mul_a, mul_b, mul;
  ray                 out_ray;
  logic               term_pulse, accept, term;
  assign accept = state == IDLE && bus.in_valid;
  assign term   = bus.in_depth >= DEPTH_W'(MAX_DEPTH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept && !term ? DX : IDLE;
      DX:      state_nx = DY;
      DY:      state_nx = DZ;
      DZ:      state_nx = SC;
      SC:      state_nx = MX;
      MX:      state_nx = MY;
      MY:      state_nx = MZ;
      MZ:      state_nx = OUT;
      OUT:     state_nx = bus.out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready   = state == IDLE;
    bus.out_valid  = state == OUT;
    bus.out_ray    = out_ray;
    bus.out_depth  = out_depth;
    bus.term_pulse = term_pulse;
  end
  // Dot-product phase multiplies d.c*n.c, mirror phase multiplies k*n.c; both share n's component.
  always_comb begin
    mul_a = state == DX ? d.x : state == DY ? d.y : state == DZ ? d.z : k;
    mul_b = state inside {DX, MX} ? n.x : state inside {DY, MY} ? n.y : n.z;
    mul   = fMul(mul_a, mul_b);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p          <= '0;
      n          <= '0;
      d          <= '0;
      depth      <= '0;
      acc        <= '0;
      k          <= '0;
      dir_x      <= '0;
      dir_y      <= '0;
      start_r    <= '0;
      out_ray    <= '0;
      out_depth  <= '0;
      term_pulse <= 1'b0;
    end else begin
      term_pulse <= accept && term;
      if (accept) begin
        p     <= bus.in_point;
        n     <= bus.in_normal;
        d     <= bus.in_dir;
        depth <= bus.in_depth;
        acc   <= '0;
      end
      if (state inside {DX, DY, DZ}) acc <= acc + mul;
      if (state == SC) k <= acc <<< 1;
      if (state == MX) begin
        dir_x     <= d.x - mul;
        start_r.x <= p.x + (n.x >>> EPS_SHIFT);
        start_r.y <= p.y + (n.y >>> EPS_SHIFT);
        start_r.z <= p.z + (n.z >>> EPS_SHIFT);
      end
      if (state == MY) dir_y <= d.y - mul;
      if (state == MZ) begin
        out_ray.start <= start_r;
        out_ray.dir   <= '{x: dir_x, y: dir_y, z: d.z - mul};
        out_depth     <= depth + 1'b1;
      end
    end
endmodule

// File: tb/tb_reflect_ray_gen.sv
// tb_reflect_ray_gen: directed checks of reflection math, latency, termination, backpressure and reset
module tb_reflect_ray_gen;
  import light_pack::*;
  logic clk = 0;
  logic rst_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  reflect_ray_gen_if #(.DEPTH_W(4)) bus ();
  reflect_ray_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic send(input vector pt, input vector nm, input vector dr, input logic [3:0] dp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    bus.in_point  = pt;
    bus.in_normal = nm;
    bus.in_dir    = dr;
    bus.in_depth  = dp;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.term_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_term got %b exp 0", bus.term_pulse); end
    n_checks++; if (bus.out_ray !== '0) begin n_fail++; $display("FAIL reset_out_ray got %h exp 0", bus.out_ray); end
    n_checks++; if (bus.out_depth !== 4'd0) begin n_fail++; $display("FAIL reset_out_depth got %h exp 0", bus.out_depth); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_basic;
    int lat;
    send('{32'h00020000, 32'h0, 32'h00030000}, '{32'h0, 32'h00010000, 32'h0},
         '{32'h00010000, 32'hFFFF0000, 32'h0}, 4'd0);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b exp 0", bus.in_ready); end
    wait_out(lat);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL basic_latency got %0d exp 7", lat); end
    n_checks++; if (bus.out_ray.dir !== 96'h00010000_00010000_00000000) begin n_fail++; $display("FAIL basic_dir got %h exp 000100000001000000000000", bus.out_ray.dir); end
    n_checks++; if (bus.out_ray.start !== 96'h00020000_00000100_00030000) begin n_fail++; $display("FAIL basic_start got %h exp 000200000000010000030000", bus.out_ray.start); end
    n_checks++; if (bus.out_depth !== 4'd1) begin n_fail++; $display("FAIL basic_depth got %0d exp 1", bus.out_depth); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_hs_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_hs_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_head_on;
    int lat;
    send('{32'h0, 32'h0, 32'h0}, '{32'h0, 32'h0, 32'h00010000}, '{32'h0, 32'h0, 32'hFFFF0000}, 4'd2);
    wait_out(lat);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL head_latency got %0d exp 7", lat); end
    n_checks++; if (bus.out_ray.dir !== 96'h00000000_00000000_00010000) begin n_fail++; $display("FAIL head_dir got %h exp 000000000000000000010000", bus.out_ray.dir); end
    n_checks++; if (bus.out_ray.start !== 96'h00000000_00000000_00000100) begin n_fail++; $display("FAIL head_start got %h exp 000000000000000000000100", bus.out_ray.start); end
    n_checks++; if (bus.out_depth !== 4'd3) begin n_fail++; $display("FAIL head_depth got %0d exp 3", bus.out_depth); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_grazing;
    int lat;
    bus.out_ready = 1'b1;
    send('{32'h0, 32'h0, 32'h0}, '{32'h0, 32'h00010000, 32'h0}, '{32'h00010000, 32'h0, 32'h0}, 4'd0);
    wait_out(lat);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL graze_latency got %0d exp 7", lat); end
    n_checks++; if (bus.out_ray.dir !== 96'h00010000_00000000_00000000) begin n_fail++; $display("FAIL graze_dir got %h exp 000100000000000000000000", bus.out_ray.dir); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL graze_hs_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL graze_hs_ready got %b exp 1", bus.in_ready); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_depth_term;
    int bad;
    send('{32'h1, 32'h2, 32'h3}, '{32'h0, 32'h00010000, 32'h0}, '{32'h00010000, 32'h0, 32'h0}, 4'd3);
    n_checks++; if (bus.term_pulse !== 1'b1) begin n_fail++; $display("FAIL term_pulse got %b exp 1", bus.term_pulse); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL term_ready got %b exp 1", bus.in_ready); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.term_pulse !== 1'b0) begin n_fail++; $display("FAIL term_pulse_end got %b exp 0", bus.term_pulse); end
    send('{32'h0, 32'h0, 32'h0}, '{32'h0, 32'h00010000, 32'h0}, '{32'h0, 32'h0, 32'h0}, 4'd15);
    send('{32'h0, 32'h0, 32'h0}, '{32'h0, 32'h00010000, 32'h0}, '{32'h0, 32'h0, 32'h0}, 4'd4);
    n_checks++; if (bus.term_pulse !== 1'b1) begin n_fail++; $display("FAIL term_b2b got %b exp 1", bus.term_pulse); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL term_no_output got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    send('{32'h0, 32'h0, 32'h0}, '{32'h00010000, 32'h0, 32'h0}, '{32'h00008000, 32'h00008000, 32'h0}, 4'd1);
    wait_out(lat);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL bp_latency got %0d exp 7", lat); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_depth !== 4'd2 ||
          bus.out_ray !== 192'h00000100_00000000_00000000_FFFF8000_00008000_00000000) bad++;
      @(posedge clk);
      #1;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles exp 0 (ray %h)", bad, bus.out_ray); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back;
    int lat;
    bus.out_ready = 1'b1;
    send('{32'h0, 32'h0, 32'h0}, '{32'h0, 32'h0, 32'h00010000}, '{32'h0, 32'h0, 32'hFFFF0000}, 4'd0);
    wait_out(lat);
    n_checks++; if (bus.out_ray.dir !== 96'h00000000_00000000_00010000) begin n_fail++; $display("FAIL b2b_first_dir got %h exp 000000000000000000010000", bus.out_ray.dir); end
    send('{32'h00010000, 32'h0, 32'h0}, '{32'hFFFF0000, 32'h0, 32'h0}, '{32'hFFFF0000, 32'h0, 32'h0}, 4'd0);
    wait_out(lat);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL b2b_latency got %0d exp 7", lat); end
    n_checks++; if (bus.out_ray.dir !== 96'h00010000_00000000_00000000) begin n_fail++; $display("FAIL b2b_dir got %h exp 000100000000000000000000", bus.out_ray.dir); end
    n_checks++; if (bus.out_ray.start !== 96'h0000FF00_00000000_00000000) begin n_fail++; $display("FAIL b2b_start got %h exp 0000ff000000000000000000", bus.out_ray.start); end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat;
    int bad;
    send('{32'h0, 32'h0, 32'h0}, '{32'h0, 32'h00010000, 32'h0}, '{32'h00010000, 32'hFFFF0000, 32'h0}, 4'd0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_ray !== '0) begin n_fail++; $display("FAIL rstmid_ray got %h exp 0", bus.out_ray); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_idle got %0d bad cycles exp 0", bad); end
    send('{32'h00020000, 32'h0, 32'h00030000}, '{32'h0, 32'h00010000, 32'h0},
         '{32'h00010000, 32'hFFFF0000, 32'h0}, 4'd0);
    wait_out(lat);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL rstmid_latency got %0d exp 7", lat); end
    n_checks++; if (bus.out_ray !== 192'h00020000_00000100_00030000_00010000_00010000_00000000) begin n_fail++; $display("FAIL rstmid_ray_after got %h", bus.out_ray); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_point  = '0;
    bus.in_normal = '0;
    bus.in_dir    = '0;
    bus.in_depth  = '0;
    bus.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_head_on;
    test_grazing;
    test_depth_term;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
